// File: rtl/apb_pkg.sv
// apb_pkg: types and constants shared by the APB requester and the APB memory bench.
//   apb_state_e : requester FSM states (IDLE, SETUP, ACCESS)
//   APB_ADDR_W  : default address width
//   APB_DATA_W  : default data width
package apb_pkg;

   localparam int APB_ADDR_W = 16;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester with a wait-state timeout.
//   clk, Rst          : clock, synchronous active-high reset
//   cmd_valid/ready   : command handshake; cmd_write/addr/wdata are latched on accept
//   rsp_valid         : one-cycle completion pulse carrying rsp_rdata and rsp_err
//   PAddr..PEnable    : registered APB requester outputs
//   PRData, PReady    : APB completer inputs
// A command takes at least three cycles (accept, SETUP, ACCESS). Each ACCESS
// cycle with PReady low advances the wait counter; when it has already reached
// TIMEOUT-1 the transfer is abandoned and reported with rsp_err.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] PAddr,
   output logic [DATA_W-1:0] PWData,
   output logic              PWrite,
   output logic              PSel,
   output logic              PEnable,
   input  logic [DATA_W-1:0] PRData,
   input  logic              PReady
);

   localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

   apb_state_e        state_q,     state_d;
   logic [7:0]        wcnt_q,      wcnt_d;
   logic [ADDR_W-1:0] paddr_q,     paddr_d;
   logic [DATA_W-1:0] pwdata_q,    pwdata_d;
   logic              pwrite_q,    pwrite_d;
   logic              psel_q,      psel_d;
   logic              penable_q,   penable_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q,   rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      cmd_ready_d = 1'b0;
      // Response fields are only non-zero for the single completion cycle.
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;

      unique case (state_q)
         IDLE: begin
            // cmd_ready is registered, so it stays low for the first cycle
            // after reset and no command can slip in before then.
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               state_d     = SETUP;
               psel_d      = 1'b1;
               penable_d   = 1'b0;
               paddr_d     = cmd_addr;
               pwdata_d    = cmd_wdata;
               pwrite_d    = cmd_write;
               wcnt_d      = '0;
               cmd_ready_d = 1'b0;
            end
         end

         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end

         ACCESS: begin
            if (PReady) begin
               state_d     = IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? '0 : PRData;
               cmd_ready_d = 1'b1;
            end else if (wcnt_q == WCNT_LAST) begin
               // Completer never answered: abandon and flag the error.
               state_d     = IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               cmd_ready_d = 1'b1;
            end else begin
               wcnt_d = wcnt_q + 8'd1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         wcnt_q      <= '0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign PAddr     = paddr_q;
   assign PWData    = pwdata_q;
   assign PWrite    = pwrite_q;
   assign PSel      = psel_q;
   assign PEnable   = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: apb_master against a 256x32 APB memory whose PReady is held
// low for a programmable number of ACCESS cycles (waits_cfg; 255 = stuck low).
// Expected responses go into a queue as commands are issued and are popped by
// a monitor whenever rsp_valid is seen.
module tb_apb_master;
   import apb_pkg::*;

   logic        clk = 1'b0;
   logic        Rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [15:0] PAddr;
   logic [31:0] PWData, PRData;
   logic        PWrite, PSel, PEnable, PReady;

   always #5 clk = ~clk;

   apb_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .Rst(Rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PAddr(PAddr), .PWData(PWData), .PWrite(PWrite), .PSel(PSel),
      .PEnable(PEnable), .PRData(PRData), .PReady(PReady)
   );

   // ---------------- APB memory with programmable wait states ----------------
   logic [31:0] mem [256];
   int          waits_cfg = 0;
   int          acc_cnt   = 0;

   assign PReady = (acc_cnt >= waits_cfg);
   assign PRData = mem[PAddr[7:0]];

   always @(posedge clk) begin
      if (PSel && PEnable && !PReady) acc_cnt <= acc_cnt + 1;
      else                            acc_cnt <= 0;
      if (Rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (PSel && PEnable && PReady && PWrite) begin
         mem[PAddr[7:0]] <= PWData;
      end
   end

   // ---------------- checking ----------------
   int errors = 0;
   int checks = 0;
   int n_accept = 0;

   typedef struct packed { logic err; logic [31:0] rdata; } exp_t;
   exp_t exp_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) if (!Rst && cmd_valid && cmd_ready) n_accept <= n_accept + 1;

   always @(negedge clk) begin
      if (rsp_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp_valid", 64'(rsp_valid), 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_ready();
      @(negedge clk);
      for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge clk);
      chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
   endtask

   // Issues one command; returns just after the accepting edge.
   task automatic do_cmd(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                         input int waits, input logic e_err, input logic [31:0] e_rd);
      wait_ready();
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
      waits_cfg = waits;
      exp_q.push_back('{err: e_err, rdata: e_rd});
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
      chk("rsp_outstanding", 64'(exp_q.size()), 64'd0);
   endtask

   // Watches a transfer from just after accept until rsp_valid.
   task automatic watch(input logic [15:0] a, output int pen, output int bad, output logic rdy);
      pen = 0; bad = 0; rdy = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            rdy = cmd_ready;
            return;
         end
         if (PEnable) begin
            pen++;
            if (PAddr !== a) bad++;
         end
      end
      pen = -1;
   endtask

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic        e_err;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs[13];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int pen, bad, busy_bad;
      logic rdy;

      vecs[0]  = '{1'b0, 16'h0010, 32'h0,        0,  1'b0, 32'hDEADBEEF};
      vecs[1]  = '{1'b1, 16'h0022, 32'hA5A50001, 1,  1'b0, 32'h0};
      vecs[2]  = '{1'b0, 16'h0022, 32'h0,        0,  1'b0, 32'hA5A50001};
      vecs[3]  = '{1'b1, 16'h00FF, 32'h12345678, 2,  1'b0, 32'h0};
      vecs[4]  = '{1'b0, 16'h00FF, 32'h0,        3,  1'b0, 32'h12345678};
      vecs[5]  = '{1'b0, 16'h0033, 32'h0,        0,  1'b0, 32'h0};
      vecs[6]  = '{1'b1, 16'h0010, 32'hCAFEF00D, 0,  1'b0, 32'h0};
      vecs[7]  = '{1'b0, 16'h0010, 32'h0,        1,  1'b0, 32'hCAFEF00D};
      vecs[8]  = '{1'b1, 16'h0044, 32'hFFFFFFFF, 15, 1'b0, 32'h0};  // ready on last allowed cycle
      vecs[9]  = '{1'b0, 16'h0044, 32'h0,        0,  1'b0, 32'hFFFFFFFF};
      vecs[10] = '{1'b0, 16'h0044, 32'h0,        16, 1'b1, 32'h0};  // one cycle too late
      vecs[11] = '{1'b1, 16'h0055, 32'h11111111, 16, 1'b1, 32'h0};
      vecs[12] = '{1'b0, 16'h0055, 32'h0,        0,  1'b0, 32'h0};  // aborted write left no trace

      // ---- reset state ----
      Rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_psel", 64'(PSel), 64'd0);
      chk("rst_penable", 64'(PEnable), 64'd0);
      chk("rst_pwrite", 64'(PWrite), 64'd0);
      chk("rst_paddr", 64'(PAddr), 64'd0);
      chk("rst_pwdata", 64'(PWData), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      Rst = 1'b0;
      @(negedge clk);
      chk("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

      // ---- cycle-exact write ----
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0010; cmd_wdata = 32'hDEADBEEF;
      waits_cfg = 0;
      exp_q.push_back('{err: 1'b0, rdata: 32'h0});
      @(posedge clk);
      #1 cmd_valid = 1'b0; cmd_addr = 16'h7777; cmd_wdata = 32'h0;
      @(negedge clk);
      chk("setup_psel", 64'(PSel), 64'd1);
      chk("setup_penable", 64'(PEnable), 64'd0);
      chk("setup_paddr", 64'(PAddr), 64'h0010);
      chk("setup_pwdata", 64'(PWData), 64'hDEADBEEF);
      chk("setup_pwrite", 64'(PWrite), 64'd1);
      chk("setup_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      chk("access_psel", 64'(PSel), 64'd1);
      chk("access_penable", 64'(PEnable), 64'd1);
      @(negedge clk);
      chk("done_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("done_psel", 64'(PSel), 64'd0);
      chk("done_penable", 64'(PEnable), 64'd0);
      chk("done_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("idle_paddr_held", 64'(PAddr), 64'h0010);
      @(negedge clk);
      chk("rsp_valid_one_cycle", 64'(rsp_valid), 64'd0);

      // ---- table-driven transfers ----
      foreach (vecs[i]) begin
         do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
                vecs[i].e_err, vecs[i].e_rdata);
         wait_drain();
      end

      // ---- wait states: PEnable high 4 cycles, PAddr stable ----
      do_cmd(1'b0, 16'h0022, 32'h0, 3, 1'b0, 32'hA5A50001);
      watch(16'h0022, pen, bad, rdy);
      chk("wait_penable_cycles", 64'(pen), 64'd4);
      chk("wait_paddr_unstable", 64'(bad), 64'd0);
      wait_drain();

      // ---- timeout: 16 ACCESS cycles, then error response ----
      do_cmd(1'b0, 16'h0010, 32'h0, 255, 1'b1, 32'h0);
      watch(16'h0010, pen, bad, rdy);
      chk("timeout_access_cycles", 64'(pen), 64'd16);
      chk("timeout_cmd_ready", 64'(rdy), 64'd1);
      wait_drain();
      waits_cfg = 0;

      // ---- reset in the middle of ACCESS ----
      wait_ready();
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0066; cmd_wdata = 32'h66666666;
      waits_cfg = 255;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_access_penable", 64'(PEnable), 64'd1);
      Rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_psel", 64'(PSel), 64'd0);
      chk("rst_mid_penable", 64'(PEnable), 64'd0);
      chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_mid_paddr", 64'(PAddr), 64'd0);
      Rst = 1'b0;
      waits_cfg = 0;
      @(negedge clk);
      chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_mid_no_rsp", 64'(rsp_valid), 64'd0);

      // ---- busy: cmd_valid held, cmd inputs churn during the transfer ----
      wait_ready();
      n_accept = 0;
      busy_bad = 0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0020; cmd_wdata = 32'h0BADC0DE;
      waits_cfg = 2;
      exp_q.push_back('{err: 1'b0, rdata: 32'h0});
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 cmd_addr = cmd_addr + 16'd1; cmd_wdata = ~cmd_wdata; cmd_write = ~cmd_write;
         @(negedge clk);
         if (rsp_valid) begin
            cmd_valid = 1'b0;
            break;
         end
         if (PAddr !== 16'h0020 || cmd_ready !== 1'b0) busy_bad++;
      end
      cmd_valid = 1'b0;
      chk("busy_inflight_disturbed", 64'(busy_bad), 64'd0);
      wait_drain();
      chk("busy_accept_count", 64'(n_accept), 64'd1);
      waits_cfg = 0;
      do_cmd(1'b0, 16'h0020, 32'h0, 0, 1'b0, 32'h0BADC0DE);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
